seg_display_reader: RTL and testbench
=====================================

# seg_display_reader

Monitors the multiplexed 8-digit, active-low 7-segment display bus and reconstructs the displayed value. It sits passively on the same `display`/`d`/`dp` nets driven by the board's display logic, reading them back rather than writing them. Each digit position is captured into a BCD-style register after its select/segment pattern has been stable long enough to reject scan ghosting. The block is used for self-check and for driving the displayed value back into other logic.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive sampled cycles a bus pattern must hold before capture. Legal range is 1 to 255.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `display`  in  8: active-low digit select; exactly one bit low selects digit i (bit i).
- `d`  in  7: active-low segments, d[6]=g … d[0]=a.
- `dp`  in  1: active-low decimal point.
- `clr`  in  1: synchronous clear of `valid`, `err` and the frame mask.
- `digits`  out  32: digit i at [4i+3:4i]. Codes are 0–9, 4'hE = blank, 4'hF = illegal pattern.
- `dp_out`  out  8: captured decimal points, active-high, bit i per digit.
- `valid`  out  8: bit i set once digit i has been captured since reset/clr.
- `frame_done`  out  1: one-cycle pulse when all 8 digits have been captured since the last pulse, reset or clr.
- `err`  out  1: sticky error flag.

## Operation
- **Input stage:** `{display,d,dp}` are registered once into sample register S.
- **Select decode on S:**
  - Exactly one bit low: legal selection, index i.
  - All high: idle. No capture; stability counter held at 0.
  - Two or more low: set `err`, no capture, counter to 0.
- **Stability counter:**
  - Increments while S equals the previous S and the selection is legal. It saturates.
  - Any change in S resets it to 1 if the new selection is legal, else to 0.
  - Capture fires exactly once per stable run, on the cycle the counter reaches `STABLE_CYCLES`. No re-capture until S changes.
- **Segment decode** (d, MSB g first):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - 1111111→E
  - Any other pattern→F, and sets `err` on capture.
- **Capture of digit i:**
  - `digits[4i+3:4i]` ← decoded code.
  - `dp_out[i]` ← ~dp.
  - `valid[i]` ← 1.
  - Frame mask bit i ← 1.
- **Frame completion:**
  - When a capture makes the frame mask all ones, `frame_done` pulses on the next cycle and the mask clears.
  - Recapturing an already-set digit does not advance the frame.
- **`clr`:**
  - Clears `valid`, the frame mask and `err`. `digits`/`dp_out` are retained.
  - `clr` has priority over a same-cycle capture: that capture is discarded entirely, and `frame_done`=0 that cycle.
  - The stability counter is not affected by `clr`.
- **Simultaneous events:** an illegal-pattern capture and a multi-select error cannot coincide. Setting `err` while `err` is already set has no effect.

## Timing
- Reset values:
  - `digits`=32'hEEEEEEEE, `dp_out`=0, `valid`=0, `frame_done`=0, `err`=0.
  - S=8'hFF/7'h7F/1 (idle), counter=0, frame mask=0.
- **Capture latency:** new bus values are sampled into S at edge 0 and held. The capture decision is made in the cycle after edge `STABLE_CYCLES`−1, and outputs are visible after edge `STABLE_CYCLES`. With the default, outputs are visible after edge 4.
- A pattern held for fewer than `STABLE_CYCLES` samples is never captured.
- **`frame_done`:** high for exactly one cycle, the cycle after the completing capture edge.
- **`err`:** set on the edge following the offending sample (multi-select) or at the capture edge (illegal pattern).
- **Reset mid-run:** `rst` asserted in any cycle returns all state to reset values on that edge. Stability counting restarts from the next sample.

## Test plan
- **Basic capture:** hold display=8'hFE, d=7'b0100100, dp=0 for 6 cycles → after edge 4, `digits[3:0]`=2, `dp_out[0]`=1, `valid`=8'h01, `err`=0.
- **Glitch rejection:** hold display=8'hFD, d=7'b1111001 for 3 cycles, then switch to 8'hFB → `valid[1]` stays 0. After 4+ cycles on 8'hFB, `valid`=8'h04.
- **Full frame:** scan digits 0–7 with 0–7 respectively, 6 cycles each → `digits`=32'h76543210, `valid`=8'hFF. `frame_done` pulses once, one cycle after the digit-7 capture. A second identical scan gives a second single pulse.
- **Errors:**
  - display=8'hFC for 1 cycle → `err`=1, no `valid` change.
  - `clr` → `err`=0, `valid`=0, `digits` unchanged.
  - d=7'b0101010 on digit 3 held 5 cycles → `digits[15:12]`=F, `err`=1.
- **Priority/reset:**
  - Assert `clr` on the capture cycle → no capture, `valid`=0.
  - Assert `rst` with counter=3 → all outputs reset. Held pattern captured 4 samples after reset deasserts.

Source files
------------

// File: rtl/seg_display_reader.sv
// seg_display_reader
// Passive read-back of a multiplexed 8-digit, active-low 7-segment display bus.
// The bus is registered once into a sample register. A digit is captured only
// after the same legal select/segment pattern has been sampled STABLE_CYCLES
// times in a row, which rejects scan ghosting during digit transitions.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   display[7:0] : active-low digit select (one low bit = digit index)
//   d[6:0]       : active-low segments, d[6]=g .. d[0]=a
//   dp           : active-low decimal point
//   clr          : clears valid, err and the frame mask (digits/dp_out kept)
//   digits[31:0] : digit i at [4i+3:4i]; 0-9, E = blank, F = illegal
//   dp_out[7:0]  : captured decimal points, active-high
//   valid[7:0]   : digit captured since reset/clr
//   frame_done   : one-cycle pulse when all 8 digits have been captured
//   err          : sticky error (multi-select or illegal segment pattern)
module seg_display_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  display,
    input  logic [6:0]  d,
    input  logic        dp,
    input  logic        clr,
    output logic [31:0] digits,
    output logic [7:0]  dp_out,
    output logic [7:0]  valid,
    output logic        frame_done,
    output logic        err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [7:0] s_sel;
    logic [6:0] s_seg;
    logic       s_dp;
    logic [7:0] cnt;
    logic       fired;   // capture already taken for the current stable run
    logic [7:0] mask;

    logic [7:0] in_lo, s_lo, mask_nxt;
    logic       in_same, in_legal, s_legal, s_multi, capture;
    logic [2:0] idx;
    logic [3:0] code;

    always_comb begin
        in_lo    = ~display;
        s_lo     = ~s_sel;
        in_same  = ({display, d, dp} == {s_sel, s_seg, s_dp});
        in_legal = (in_lo != 8'd0) && ((in_lo & (in_lo - 8'd1)) == 8'd0);
        s_legal  = (s_lo != 8'd0) && ((s_lo & (s_lo - 8'd1)) == 8'd0);
        s_multi  = (s_lo != 8'd0) && !s_legal;

        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (s_lo[i]) idx = 3'(i);

        capture  = s_legal && (cnt == STABLE) && !fired;
        mask_nxt = mask | (8'd1 << idx);

        case (s_seg)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b1111111: code = 4'hE;
            default:    code = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_sel      <= 8'hFF;
            s_seg      <= 7'h7F;
            s_dp       <= 1'b1;
            cnt        <= 8'd0;
            fired      <= 1'b0;
            mask       <= 8'd0;
            digits     <= 32'hEEEE_EEEE;
            dp_out     <= 8'd0;
            valid      <= 8'd0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            s_sel <= display;
            s_seg <= d;
            s_dp  <= dp;

            // The counter tracks how many consecutive samples the value now
            // entering S has been seen; it restarts whenever S changes.
            if (!in_same) begin
                cnt   <= in_legal ? 8'd1 : 8'd0;
                fired <= 1'b0;
            end else begin
                if (in_legal && cnt != 8'hFF) cnt <= cnt + 8'd1;
                if (capture) fired <= 1'b1;
            end

            frame_done <= 1'b0;
            if (clr) begin
                // A capture in this cycle is dropped, but fired still latches
                // so the same run is not taken later.
                valid <= 8'd0;
                mask  <= 8'd0;
                err   <= 1'b0;
            end else begin
                if (capture) begin
                    digits[idx*4 +: 4] <= code;
                    dp_out[idx]        <= ~s_dp;
                    valid[idx]         <= 1'b1;
                    if (mask_nxt == 8'hFF) begin
                        mask       <= 8'd0;
                        frame_done <= 1'b1;
                    end else begin
                        mask <= mask_nxt;
                    end
                    if (code == 4'hF) err <= 1'b1;
                end
                if (s_multi) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_reader.sv
// Randomized + directed bench for seg_display_reader. The driver applies one
// bus value per cycle, advances a history-based reference model and queues the
// expected outputs; a monitor pops and compares after every rising edge.
module tb_seg_display_reader;

    localparam int N = 4;
    localparam logic [15:0] IDLE = 16'hFFFF;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk;
    logic        rst, clr, dp;
    logic [7:0]  display;
    logic [6:0]  d;
    logic [31:0] digits;
    logic [7:0]  dp_out, valid;
    logic        frame_done, err;

    seg_display_reader #(.STABLE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .display(display), .d(d), .dp(dp), .clr(clr),
        .digits(digits), .dp_out(dp_out), .valid(valid),
        .frame_done(frame_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dpo;
        logic [7:0]  vld;
        logic        fd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model state
    logic [15:0] hist[$];     // last N+1 values held in the sample register
    logic [31:0] m_digits;
    logic [7:0]  m_dpo, m_vld, m_seen;
    logic        m_fd, m_err;

    function automatic logic [3:0] seg_code(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (s == SEG_TAB[i]) return 4'(i);
        if (s == 7'h7F) return 4'hE;
        return 4'hF;
    endfunction

    task automatic model_edge(input logic [15:0] v_in, input logic c, input logic r);
        logic [15:0] v;
        logic        run_ok;
        int          lows, pos;
        logic [3:0]  cd;
        if (r) begin
            m_digits = 32'hEEEE_EEEE; m_dpo = 0; m_vld = 0; m_seen = 0;
            m_fd = 0; m_err = 0;
            hist.delete(); hist.push_back(IDLE);
        end else begin
            v = hist[$];
            lows = 0; pos = 0;
            for (int i = 0; i < 8; i++)
                if (!v[8+i]) begin lows++; pos = i; end
            // Capture when exactly the last N samples hold one legal value
            // and the sample before them was different.
            run_ok = (hist.size() == N + 1) && (lows == 1) && (hist[0] != v);
            for (int j = 1; j <= N; j++)
                if (hist.size() == N + 1 && hist[j] != v) run_ok = 0;
            m_fd = 0;
            if (c) begin
                m_vld = 0; m_seen = 0; m_err = 0;
            end else begin
                if (run_ok) begin
                    cd = seg_code(v[7:1]);
                    m_digits[pos*4 +: 4] = cd;
                    m_dpo[pos] = ~v[0];
                    m_vld[pos] = 1;
                    m_seen[pos] = 1;
                    if (m_seen == 8'hFF) begin m_fd = 1; m_seen = 0; end
                    if (cd == 4'hF) m_err = 1;
                end
                if (lows >= 2) m_err = 1;
            end
            hist.push_back(v_in);
            if (hist.size() > N + 1) void'(hist.pop_front());
        end
    endtask

    task automatic cyc(input logic [7:0] di, input logic [6:0] dd, input logic ddp,
                       input logic c, input logic r);
        exp_t e;
        @(negedge clk); #1;
        display = di; d = dd; dp = ddp; clr = c; rst = r;
        model_edge({di, dd, ddp}, c, r);
        e.digits = m_digits; e.dpo = m_dpo; e.vld = m_vld; e.fd = m_fd; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [7:0] di, input logic [6:0] dd, input logic ddp,
                        input int n);
        for (int k = 0; k < n; k++) cyc(di, dd, ddp, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, ex);
        end
    endtask

    // Monitor: one expected snapshot per rising edge.
    always begin
        exp_t e;
        @(posedge clk); #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("digits", digits, e.digits);
            chk("dp_out", 32'(dp_out), 32'(e.dpo));
            chk("valid", 32'(valid), 32'(e.vld));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("err", 32'(err), 32'(e.err));
            cyc_no++;
        end
    end

    initial begin
        logic [7:0] sel;
        logic [6:0] sg;
        int a, b, len;
        rst = 1; clr = 0; display = 8'hFF; d = 7'h7F; dp = 1;

        cyc(8'hFF, 7'h7F, 1, 0, 1);
        cyc(8'hFF, 7'h7F, 1, 0, 1);

        // basic capture
        hold(8'hFE, 7'b0100100, 0, 6);
        // glitch rejection
        hold(8'hFD, 7'b1111001, 1, 3);
        hold(8'hFB, 7'b1111001, 1, 5);
        // two full frames
        cyc(8'hFF, 7'h7F, 1, 1, 0);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++)
                hold(~(8'd1 << i), SEG_TAB[i], 1, 6);
        // multi-select, clear, illegal pattern
        hold(8'hFC, 7'h7F, 1, 1);
        hold(8'hFF, 7'h7F, 1, 2);
        cyc(8'hFF, 7'h7F, 1, 1, 0);
        hold(8'hF7, 7'b0101010, 1, 5);
        hold(8'hFF, 7'h7F, 1, 2);
        // clr on the capture cycle
        cyc(8'hFF, 7'h7F, 1, 1, 0);
        for (int k = 0; k < 6; k++) cyc(8'hEF, SEG_TAB[8], 0, (k == N), 0);
        // reset mid-run with three samples counted
        hold(8'hBF, SEG_TAB[5], 1, 3);
        cyc(8'hBF, SEG_TAB[5], 1, 0, 1);
        hold(8'hBF, SEG_TAB[5], 1, 6);

        // random scan traffic
        for (int s = 0; s < 300; s++) begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            case ($urandom_range(0, 9))
                0:       sel = 8'hFF;
                1:       sel = ~((8'd1 << a) | (8'd1 << b));
                default: sel = ~(8'd1 << a);
            endcase
            case ($urandom_range(0, 9))
                0:       sg = 7'h7F;
                1:       sg = 7'($urandom);
                default: sg = SEG_TAB[$urandom_range(0, 9)];
            endcase
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                cyc(sel, sg, 1'($urandom), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 59) == 0));
        end
        hold(8'hFF, 7'h7F, 1, 2);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
